store_buffer: RTL

Word-granular store buffer between the MEM pipeline stage and the data memory. Accepts stores from the pipeline in one cycle, queues them in a small FIFO, and drains one entry per cycle into the data memory whenever the memory port is not needed for a load. Loads pass straight through to the data memory's combinational read path, with youngest-match forwarding from buffered stores. The buffer hides memory write traffic from the pipeline; its only stall source is a full buffer or, when forwarding is compiled out, a load that hits a buffered address.

---
 rtl/mips_mem_pkg.sv | 15 +
 rtl/store_buffer_fifo.sv | 83 ++++++++
 rtl/store_buffer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared data-memory definitions for the MIPS memory stage: data segment base,
// store buffer entry layout and default buffer depth.
package mips_mem_pkg;

    localparam logic [31:0] DATA_BASE     = 32'h1001_0000;
    localparam int          SB_DEPTH      = 4;
    localparam int          SB_DATA_WIDTH = 32;

    typedef struct packed {
        logic                     valid;
        logic [SB_DATA_WIDTH-1:0] addr;
        logic [SB_DATA_WIDTH-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Store buffer entry storage: circular queue of {valid, addr, data} with head/tail
// pointers and occupancy count. Push into a full queue and pop from an empty one are ignored.
module store_buffer_fifo
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = SB_DATA_WIDTH,
    parameter int DEPTH      = SB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DATA_WIDTH-1:0]      i_addr,
    input  logic [DATA_WIDTH-1:0]      i_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH)-1:0]   o_tail,
    output logic [DATA_WIDTH-1:0]      o_head_addr,
    output logic [DATA_WIDTH-1:0]      o_head_data,
    output logic [DEPTH-1:0]           o_valid,
    output logic [DATA_WIDTH-1:0]      o_addr [DEPTH],
    output logic [DATA_WIDTH-1:0]      o_data [DEPTH]
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == {CW{1'b0}});
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Entry writes at tail, invalidation at head, pointer and count update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= '{valid: 1'b1,
                                   addr:  SB_DATA_WIDTH'(i_addr),
                                   data:  SB_DATA_WIDTH'(i_data)};
                r_tail        <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_mem[r_head].valid <= 1'b0;
                r_head              <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Expose every entry for the address match in the parent
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_valid[i] = r_mem[i].valid;
            o_addr[i]  = DATA_WIDTH'(r_mem[i].addr);
            o_data[i]  = DATA_WIDTH'(r_mem[i].data);
        end
    end

    assign o_count     = r_count;
    assign o_tail      = r_tail;
    assign o_head_addr = DATA_WIDTH'(r_mem[r_head].addr);
    assign o_head_data = DATA_WIDTH'(r_mem[r_head].data);

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data memory with youngest-match load forwarding.
// Define STORE_FORWARD_EN to forward buffered data; otherwise a matching load stalls until drained.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = SB_DATA_WIDTH,
    parameter int DEPTH      = SB_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemWrite_i,
    input  logic                  MemRead_i,
    input  logic [DATA_WIDTH-1:0] Address_i,
    input  logic [DATA_WIDTH-1:0] WriteData_i,
    output logic [DATA_WIDTH-1:0] ReadData_o,
    output logic                  Stall_o,
    output logic                  Empty_o,
    output logic                  MemWrite_o,
    output logic                  MemRead_o,
    output logic [DATA_WIDTH-1:0] Address_o,
    output logic [DATA_WIDTH-1:0] WriteData_o,
    input  logic [DATA_WIDTH-1:0] ReadData_i
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]           w_count;
    logic                  w_full;
    logic                  w_empty;
    logic [PW-1:0]         w_tail;
    logic [DATA_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [DEPTH-1:0]      w_valid;
    logic [DATA_WIDTH-1:0] w_addr [DEPTH];
    logic [DATA_WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH-1:0]      w_match;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_fwd_data;
    logic                  w_load;
    logic                  w_load_stall;
    logic                  w_push;
    logic                  w_drain;

    store_buffer_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .i_push      (w_push),
        .i_pop       (w_drain),
        .i_addr      (Address_i),
        .i_data      (WriteData_i),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_tail      (w_tail),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_valid     (w_valid),
        .o_addr      (w_addr),
        .o_data      (w_data)
    );

    // Full-address match; scanning oldest to youngest lets the youngest hit win
    always_comb begin
        logic [PW-1:0] idx;
        w_match    = {DEPTH{1'b0}};
        w_fwd_data = {DATA_WIDTH{1'b0}};
        idx        = {PW{1'b0}};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx          = w_tail - PW'(k + 1);
            w_match[idx] = w_valid[idx] & (w_addr[idx] == Address_i);
            w_fwd_data   = w_match[idx] ? w_data[idx] : w_fwd_data;
        end
    end

    assign w_hit  = |w_match;
    // A simultaneous read+write request is handled as a store only
    assign w_load = MemRead_i & ~MemWrite_i;

`ifdef STORE_FORWARD_EN
    assign w_load_stall = 1'b0;
`else
    assign w_load_stall = w_load & w_hit;
`endif

    assign w_push  = MemWrite_i & ~w_full;
    assign w_drain = ~w_empty & (~MemRead_i | w_load_stall);
    assign Empty_o = (w_count == '0);

    // Memory port arbitration: drain owns the port unless a non-stalled load needs it
    always_comb begin
        MemWrite_o  = 1'b0;
        MemRead_o   = 1'b0;
        Address_o   = {DATA_WIDTH{1'b0}};
        WriteData_o = {DATA_WIDTH{1'b0}};
        if (!reset) begin
            MemWrite_o = 1'b0;
        end else if (w_drain) begin
            MemWrite_o  = 1'b1;
            Address_o   = w_head_addr;
            WriteData_o = w_head_data;
        end else if (w_load) begin
            MemRead_o = 1'b1;
            Address_o = Address_i;
        end else begin
            MemRead_o = 1'b0;
        end
    end

    // Load result and pipeline stall
    always_comb begin
        ReadData_o = {DATA_WIDTH{1'b0}};
        Stall_o    = reset & ((MemWrite_i & w_full) | w_load_stall);
        if (reset && w_load && !w_load_stall) begin
            ReadData_o = w_hit ? w_fwd_data : ReadData_i;
        end else begin
            ReadData_o = {DATA_WIDTH{1'b0}};
        end
    end

endmodule
